rsa_stream_wrapper: RTL

- Parametrised Avalon-MM master that moves RSA traffic between the UART-style peripheral and an external modular-exponentiation core.
- Loads the key (N, then d) once.
- Then loops forever: receive a ciphertext block, pulse the core, wait for its result, transmit the plaintext minus its MSB byte.
- Generalises the 256-bit wrapper: key width is a parameter, and the core is reached through ports rather than a fixed instance, so 256/512/1024-bit cores share one wrapper.

---
 rtl/rsa_stream_wrapper.sv | 301 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/rsa_stream_wrapper.sv
// -----------------------------------------------------------------------------
// rsa_stream_wrapper
//
// Avalon-MM master that streams RSA traffic between a UART-style peripheral and
// an external modular-exponentiation core. After reset it receives the modulus
// N and then the exponent d, each KEY_BITS/8 bytes with the MSB byte first.
// It then repeats the following block loop:
//   1. Receive one ciphertext block.
//   2. Pulse core_start.
//   3. Wait for core_finished.
//   4. Transmit the result, without its most significant byte.
//
// Each received or transmitted byte is gated by a poll of the status register.
//
// Optional feature (macro RSA_WRAP_KEY_RELOAD_EN):
//   Adds input i_key_reload. A pulse requests that a fresh N and d be loaded at
//   the next block boundary.
//
// Ports:
//   avm_clk, avm_rst_n  clock, asynchronous active-low reset
//   avm_address         Avalon byte address (RX / TX / status register)
//   avm_read            read request
//   avm_readdata        read data; [7:0] carries RX bytes, status bits by param
//   avm_write           write request
//   avm_writedata       write data, {24'b0, byte}
//   avm_waitrequest     slave stall; the request is held while it is high
//   core_start          one-cycle start pulse to the exponentiation core
//   core_a              ciphertext operand
//   core_d              exponent
//   core_n              modulus
//   core_result         a^d mod n, valid with core_finished
//   core_finished       result-valid pulse from the core
//   i_key_reload        key reload request (only with RSA_WRAP_KEY_RELOAD_EN)
//   o_busy              high while waiting for the core
// -----------------------------------------------------------------------------
module rsa_stream_wrapper #(
  parameter int KEY_BITS  = 256,
  parameter int RX_ADDR   = 0,
  parameter int TX_ADDR   = 4,
  parameter int STAT_ADDR = 8,
  parameter int RX_OK_BIT = 7,
  parameter int TX_OK_BIT = 6
) (
  input  logic                avm_clk,
  input  logic                avm_rst_n,
  output logic [4:0]          avm_address,
  output logic                avm_read,
  input  logic [31:0]         avm_readdata,
  output logic                avm_write,
  output logic [31:0]         avm_writedata,
  input  logic                avm_waitrequest,
  output logic                core_start,
  output logic [KEY_BITS-1:0] core_a,
  output logic [KEY_BITS-1:0] core_d,
  output logic [KEY_BITS-1:0] core_n,
  input  logic [KEY_BITS-1:0] core_result,
  input  logic                core_finished,
`ifdef RSA_WRAP_KEY_RELOAD_EN
  input  logic                i_key_reload,
`endif
  output logic                o_busy
);

  localparam int NB = KEY_BITS / 8;
  localparam int CW = $clog2(NB + 1);

  localparam logic [CW-1:0] NB_C    = CW'(NB);
  localparam logic [CW-1:0] NB_M1_C = CW'(NB - 1);
  localparam logic [4:0]    RX_A    = 5'(RX_ADDR);
  localparam logic [4:0]    TX_A    = 5'(TX_ADDR);
  localparam logic [4:0]    STAT_A  = 5'(STAT_ADDR);

  typedef enum logic [2:0] {
    S_POLL_RX,
    S_READ_RX,
    S_CALC,
    S_POLL_TX,
    S_WRITE_TX
  } state_e;

  typedef enum logic [1:0] {
    PH_KEY_N,
    PH_KEY_D,
    PH_DATA
  } phase_e;

  state_e              state_q, state_d;
  phase_e              phase_q, phase_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4:0]          addr_q, addr_d;
  logic                read_q, read_d;
  logic                write_q, write_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                start_q, start_d;
  logic                busy_q, busy_d;
  logic [KEY_BITS-1:0] key_n_q, key_n_d;
  logic [KEY_BITS-1:0] key_d_q, key_d_d;
  logic [KEY_BITS-1:0] data_a_q, data_a_d;
  logic [KEY_BITS-1:0] out_q, out_d;

  logic                xfer_done;
  logic [CW-1:0]       cnt_inc;
  logic [7:0]          rx_byte;

`ifdef RSA_WRAP_KEY_RELOAD_EN
  logic reload_q, reload_d;
  logic reload_pend;

  // A request arriving in the same cycle as a block boundary is honoured at once.
  assign reload_pend = reload_q | i_key_reload;
`endif

  // Only the RX byte and the two status flags of the read data are consumed.
  logic unused_rdata;
  assign unused_rdata = ^avm_readdata;

  assign xfer_done = (read_q | write_q) & ~avm_waitrequest;
  assign cnt_inc   = cnt_q + CW'(1);
  assign rx_byte   = avm_readdata[7:0];

  // ---------------------------------------------------------------------------
  // Next-state and registered-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    state_d  = state_q;
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    read_d   = read_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    start_d  = 1'b0;
    key_n_d  = key_n_q;
    key_d_d  = key_d_q;
    data_a_d = data_a_q;
    out_d    = out_q;
`ifdef RSA_WRAP_KEY_RELOAD_EN
    reload_d = reload_pend;
`endif

    unique case (state_q)
      S_POLL_RX: begin
`ifdef RSA_WRAP_KEY_RELOAD_EN
        // Idle between blocks: a pending reload restarts the key load right away.
        if (reload_pend && phase_q == PH_DATA && cnt_q == '0) begin
          phase_d  = PH_KEY_N;
          reload_d = 1'b0;
        end
`endif
        if (xfer_done && avm_readdata[RX_OK_BIT]) begin
          state_d = S_READ_RX;
          addr_d  = RX_A;
        end
      end

      S_READ_RX: begin
        if (xfer_done) begin
          // Operands arrive MSB byte first, so each byte shifts in from the right.
          unique case (phase_q)
            PH_KEY_N: key_n_d  = {key_n_q[KEY_BITS-9:0], rx_byte};
            PH_KEY_D: key_d_d  = {key_d_q[KEY_BITS-9:0], rx_byte};
            default:  data_a_d = {data_a_q[KEY_BITS-9:0], rx_byte};
          endcase

          if (cnt_inc == NB_C) begin
            cnt_d = '0;
            unique case (phase_q)
              PH_KEY_N: phase_d = PH_KEY_D;
              default:  phase_d = PH_DATA;
            endcase
            if (phase_q == PH_DATA) begin
              state_d = S_CALC;
              read_d  = 1'b0;
              start_d = 1'b1;
            end else begin
              state_d = S_POLL_RX;
              addr_d  = STAT_A;
            end
          end else begin
            cnt_d   = cnt_inc;
            state_d = S_POLL_RX;
            addr_d  = STAT_A;
          end
        end
      end

      S_CALC: begin
        // core_finished is only meaningful here; elsewhere it is ignored.
        if (core_finished) begin
          out_d   = core_result;
          state_d = S_POLL_TX;
          read_d  = 1'b1;
          addr_d  = STAT_A;
        end
      end

      S_POLL_TX: begin
        if (xfer_done && avm_readdata[TX_OK_BIT]) begin
          state_d = S_WRITE_TX;
          read_d  = 1'b0;
          write_d = 1'b1;
          addr_d  = TX_A;
          // The MSB byte of the result is never sent, so send the next one down.
          wdata_d = {24'b0, out_q[KEY_BITS-9 -: 8]};
        end
      end

      S_WRITE_TX: begin
        if (xfer_done) begin
          out_d   = out_q << 8;
          write_d = 1'b0;
          wdata_d = '0;
          read_d  = 1'b1;
          addr_d  = STAT_A;
          if (cnt_inc == NB_M1_C) begin
            cnt_d   = '0;
            phase_d = PH_DATA;
            state_d = S_POLL_RX;
`ifdef RSA_WRAP_KEY_RELOAD_EN
            if (reload_pend) begin
              phase_d  = PH_KEY_N;
              reload_d = 1'b0;
            end
`endif
          end else begin
            cnt_d   = cnt_inc;
            state_d = S_POLL_TX;
          end
        end
      end

      default: begin
        state_d = S_POLL_RX;
        read_d  = 1'b1;
        write_d = 1'b0;
        addr_d  = STAT_A;
      end
    endcase

    busy_d = (state_d == S_CALC);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments only. All
  // registers then sample the values they held before the edge, whatever order
  // they are written in.
  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      state_q  <= S_POLL_RX;
      phase_q  <= PH_KEY_N;
      cnt_q    <= '0;
      addr_q   <= STAT_A;
      read_q   <= 1'b1;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      // NOTE: the operand registers are cleared on reset on purpose. A reset
      // mid-operation must discard the key so that it cannot be reused.
      key_n_q  <= '0;
      key_d_q  <= '0;
      data_a_q <= '0;
      out_q    <= '0;
`ifdef RSA_WRAP_KEY_RELOAD_EN
      reload_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      read_q   <= read_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      key_n_q  <= key_n_d;
      key_d_q  <= key_d_d;
      data_a_q <= data_a_d;
      out_q    <= out_d;
`ifdef RSA_WRAP_KEY_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign avm_address   = addr_q;
  assign avm_read      = read_q;
  assign avm_write     = write_q;
  assign avm_writedata = wdata_q;
  assign core_start    = start_q;
  assign core_a        = data_a_q;
  assign core_d        = key_d_q;
  assign core_n        = key_n_q;
  assign o_busy        = busy_q;

endmodule
